// File: rtl/vga_timing_gen.sv
// Raster timing generator: h/v counters, line/frame strobes, frame counter
// and delayed sync/de outputs aligned with the downstream effects pipeline.
module vga_timing_gen #(
  parameter int H_DISPLAY     = 1220,
  parameter int H_FRONT_PORCH = 31,
  parameter int H_SYNC_PULSE  = 183,
  parameter int H_TOTAL       = 1525,
  parameter int V_DISPLAY     = 480,
  parameter int V_FRONT_PORCH = 10,
  parameter int V_SYNC_PULSE  = 2,
  parameter int V_TOTAL       = 525,
  parameter int PREFETCH      = 16,
  parameter int PIPE_DELAY    = 2
) (
  input  logic        clk48,
  input  logic        rst_n,
  input  logic        pause_n,
  output logic [10:0] h_count,
  output logic [9:0]  v_count,
  output logic        active,
  output logic        line_end_stb,
  output logic        prefetch_stb,
  output logic        frame_stb,
  output logic [10:0] frame,
  output logic        hsync_d,
  output logic        vsync_d,
  output logic        de_d
);

  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_ACT  = 11'(H_DISPLAY);
  localparam logic [10:0] H_PRE  = 11'(H_DISPLAY - PREFETCH);
  localparam logic [10:0] HS_BEG = 11'(H_DISPLAY + H_FRONT_PORCH);
  localparam logic [10:0] HS_END =
    11'(H_DISPLAY + H_FRONT_PORCH + H_SYNC_PULSE);
  localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_ACT  = 10'(V_DISPLAY);
  localparam logic [9:0]  VS_BEG = 10'(V_DISPLAY + V_FRONT_PORCH);
  localparam logic [9:0]  VS_END =
    10'(V_DISPLAY + V_FRONT_PORCH + V_SYNC_PULSE);

  logic line_wrap;
  logic hs_raw;
  logic vs_raw;

  logic [PIPE_DELAY-1:0] hs_pipe;
  logic [PIPE_DELAY-1:0] vs_pipe;
  logic [PIPE_DELAY-1:0] de_pipe;

  // >= so that an out-of-range count still recovers on the next clock
  assign line_wrap    = h_count >= H_LAST;
  assign active       = (h_count < H_ACT) && (v_count < V_ACT);
  assign hs_raw       = !((h_count >= HS_BEG) && (h_count < HS_END));
  assign vs_raw       = !((v_count >= VS_BEG) && (v_count < VS_END));
  assign line_end_stb = h_count == H_ACT;
  assign prefetch_stb = h_count == H_PRE;
  assign frame_stb    = (h_count == H_LAST) && (v_count == V_LAST);

  always_ff @(posedge clk48) begin
    if (!rst_n) begin
      h_count <= '0;
      v_count <= '0;
      frame   <= '0;
      hs_pipe <= '1;
      vs_pipe <= '1;
      de_pipe <= '0;
    end else begin
      if (line_wrap) begin
        h_count <= '0;
        v_count <= (v_count >= V_LAST) ? 10'd0 : v_count + 10'd1;
      end else begin
        h_count <= h_count + 11'd1;
      end
      if (frame_stb && pause_n)
        frame <= frame + 11'd1;
      hs_pipe[0] <= hs_raw;
      vs_pipe[0] <= vs_raw;
      de_pipe[0] <= active;
      for (int i = 1; i < PIPE_DELAY; i++) begin
        hs_pipe[i] <= hs_pipe[i-1];
        vs_pipe[i] <= vs_pipe[i-1];
        de_pipe[i] <= de_pipe[i-1];
      end
    end
  end

  assign hsync_d = hs_pipe[PIPE_DELAY-1];
  assign vsync_d = vs_pipe[PIPE_DELAY-1];
  assign de_d    = de_pipe[PIPE_DELAY-1];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen; long spans are skipped by
// forcing the raster counters close to the boundary under test.
module tb_vga_timing_gen;

  logic        clk48;
  logic        rst_n;
  logic        pause_n;
  logic [10:0] h_count;
  logic [9:0]  v_count;
  logic        active;
  logic        line_end_stb;
  logic        prefetch_stb;
  logic        frame_stb;
  logic [10:0] frame;
  logic        hsync_d;
  logic        vsync_d;
  logic        de_d;

  int checks = 0;
  int errors = 0;

  vga_timing_gen dut (
    .clk48        (clk48),
    .rst_n        (rst_n),
    .pause_n      (pause_n),
    .h_count      (h_count),
    .v_count      (v_count),
    .active       (active),
    .line_end_stb (line_end_stb),
    .prefetch_stb (prefetch_stb),
    .frame_stb    (frame_stb),
    .frame        (frame),
    .hsync_d      (hsync_d),
    .vsync_d      (vsync_d),
    .de_d         (de_d)
  );

  initial clk48 = 1'b0;
  always #5 clk48 = ~clk48;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk48);
    #1;
  endtask

  logic [10:0] jh;
  logic [9:0]  jv;

  task jump(input logic [10:0] h, input logic [9:0] v);
    jh = h;
    jv = v;
    force dut.h_count = jh;
    force dut.v_count = jv;
    #1;
    release dut.h_count;
    release dut.v_count;
  endtask

  int hs_lo, hs_first, de_n, pf_n, pf_h, le_n, le_h, fs_n;
  int vs_lo, vs_h, vs_v;

  initial begin
    rst_n   = 1'b0;
    pause_n = 1'b1;
    repeat (3) tick;
    chk("rst_h", h_count, 0);
    chk("rst_v", v_count, 0);
    chk("rst_frame", frame, 0);
    chk("rst_hs", hsync_d, 1);
    chk("rst_vs", vsync_d, 1);
    chk("rst_de", de_d, 0);
    chk("rst_fstb", frame_stb, 0);
    chk("rst_lestb", line_end_stb, 0);
    chk("rst_active", active, 1);

    rst_n = 1'b1;
    tick;
    chk("run_h1", h_count, 1);
    chk("run_v0", v_count, 0);

    hs_lo = 0; hs_first = -1; de_n = 0;
    pf_n = 0; pf_h = -1; le_n = 0; le_h = -1; fs_n = 0;
    for (int i = 0; i < 1524; i++) begin
      if (!hsync_d) begin
        if (hs_lo == 0) hs_first = h_count;
        hs_lo++;
      end
      if (de_d) de_n++;
      if (prefetch_stb) begin pf_n++; pf_h = h_count; end
      if (line_end_stb) begin le_n++; le_h = h_count; end
      if (frame_stb) fs_n++;
      tick;
    end
    chk("hs_len", hs_lo, 183);
    chk("hs_first", hs_first, 1253);
    chk("de_len", de_n, 1220);
    chk("pf_cnt", pf_n, 1);
    chk("pf_h", pf_h, 1204);
    chk("le_cnt", le_n, 1);
    chk("le_h", le_h, 1220);
    chk("fs_line0", fs_n, 0);
    chk("wrap_h", h_count, 0);
    chk("wrap_v", v_count, 1);

    jump(11'd1524, 10'd489);
    tick;
    chk("v490_h", h_count, 0);
    chk("v490_v", v_count, 490);
    vs_lo = 0; vs_h = -1; vs_v = -1; de_n = 0;
    for (int i = 0; i < 3200; i++) begin
      if (!vsync_d) begin
        if (vs_lo == 0) begin vs_h = h_count; vs_v = v_count; end
        vs_lo++;
      end else if (vs_lo > 0) begin
        break;
      end
      if (de_d) de_n++;
      tick;
    end
    chk("vs_len", vs_lo, 3050);
    chk("vs_first_h", vs_h, 2);
    chk("vs_first_v", vs_v, 490);
    chk("de_vblank", de_n, 0);

    jump(11'd1524, 10'd524);
    chk("fstb_hi", frame_stb, 1);
    chk("fstb_le", line_end_stb, 0);
    chk("frame_pre", frame, 0);
    tick;
    chk("fwrap_h", h_count, 0);
    chk("fwrap_v", v_count, 0);
    chk("fwrap_frame", frame, 1);
    chk("fstb_lo", frame_stb, 0);

    pause_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      jump(11'd1524, 10'd524);
      chk("pause_fstb", frame_stb, 1);
      tick;
      chk("pause_frame", frame, 1);
    end
    pause_n = 1'b1;
    jump(11'd1524, 10'd524);
    tick;
    chk("unpause_frame", frame, 2);

    jump(11'd2000, 10'd100);
    tick;
    chk("seu_h", h_count, 0);
    chk("seu_hv", v_count, 101);
    jump(11'd1524, 10'd1000);
    tick;
    chk("seu_v", v_count, 0);
    chk("seu_frame", frame, 2);

    jump(11'd698, 10'd300);
    tick;
    tick;
    chk("mid_h", h_count, 700);
    chk("mid_de", de_d, 1);
    rst_n = 1'b0;
    tick;
    chk("mrst_h", h_count, 0);
    chk("mrst_v", v_count, 0);
    chk("mrst_frame", frame, 0);
    chk("mrst_hs", hsync_d, 1);
    chk("mrst_vs", vsync_d, 1);
    chk("mrst_de", de_d, 0);
    rst_n = 1'b1;

    force dut.frame = 11'd2047;
    #1;
    release dut.frame;
    jump(11'd1524, 10'd524);
    tick;
    chk("frame_roll", frame, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
